// File: rtl/teclado_senha.sv
// 4x4 active-low matrix keypad scanner with debounce, digit accumulation and
// packet emission on confirm ('#'), exit ('*') or inactivity timeout.
module teclado_senha #(
  parameter int SCAN_CYC     = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int TIMEOUT_CYC  = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  col_n,
  output logic [3:0]  lin_n,
  output logic [79:0] digitos_value,
  output logic        digitos_valid
);

  localparam int SCAN_W = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 2;
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [79:0] PKT_EMPTY = {20{4'hF}};
  localparam logic [79:0] PKT_TMO   = {20{4'hE}};
  localparam logic [79:0] PKT_EXIT  = {{19{4'hF}}, 4'hB};

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  // Internal key code: digits as their value, A-D as 'hA-'hD, '*'='hE, '#'='hF
  function automatic logic [3:0] key_of(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
      4'b11_00: k = KEY_STAR; 4'b11_01: k = 4'h0; 4'b11_10: k = KEY_HASH;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  state_t             state, state_nx;
  logic [3:0]         col_p0, col_p1;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [DEB_W-1:0]   deb_cnt;
  logic [1:0]         row_q, col_q;
  logic [1:0]         row_idx, low_col;
  logic [79:0]        buffer;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               any_low, col_low, scan_settled, scan_run;
  logic               latch, accept, deb_clr, deb_inc;
  logic [3:0]         key_val;

  // Stage p0/p1: two-flop synchroniser on the asynchronous columns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= col_n;
      col_p1 <= col_p0;
    end
  end

  always_comb begin
    case (lin_n)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
    if      (!col_p1[0]) low_col = 2'd0;
    else if (!col_p1[1]) low_col = 2'd1;
    else if (!col_p1[2]) low_col = 2'd2;
    else                 low_col = 2'd3;
  end

  assign any_low = ~&col_p1;
  assign col_low = ~col_p1[col_q];
  assign key_val = key_of(row_q, col_q);
  // The synchroniser lags the row drive by two cycles, so a column is only
  // attributed to the current row once it has been driven that long (SCAN_CYC >= 3).
  assign scan_settled = (scan_cnt >= SCAN_W'(2));

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    accept   = 1'b0;
    deb_clr  = 1'b0;
    deb_inc  = 1'b0;
    case (state)
      SCAN: begin
        if (scan_settled && any_low) begin
          latch    = 1'b1;
          deb_clr  = 1'b1;
          state_nx = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!col_low)               state_nx = SCAN;
        else if (deb_cnt == DEB_LAST) begin
          accept   = 1'b1;
          state_nx = HELD;
        end else                    deb_inc = 1'b1;
      end
      HELD: begin
        if (!col_low) begin
          deb_clr  = 1'b1;
          state_nx = DEB_REL;
        end
      end
      default: begin
        if (col_low)                deb_clr  = 1'b1;
        else if (deb_cnt == DEB_LAST) state_nx = SCAN;
        else                        deb_inc  = 1'b1;
      end
    endcase
    if (!enable) begin
      state_nx = SCAN;
      latch    = 1'b0;
      accept   = 1'b0;
    end
  end

  assign scan_run = !enable || (state == SCAN && !latch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      lin_n    <= 4'b1110;
      row_q    <= 2'd0;
      col_q    <= 2'd0;
    end else begin
      state <= state_nx;
      if (deb_clr)      deb_cnt <= '0;
      else if (deb_inc) deb_cnt <= deb_cnt + 1'b1;
      if (latch) begin
        row_q    <= row_idx;
        col_q    <= low_col;
        scan_cnt <= '0;
      end else if (scan_run) begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt <= '0;
          lin_n    <= {lin_n[2:0], lin_n[3]};
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
    end
  end

  // Packet stage: buffer, timeout and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer        <= PKT_EMPTY;
      digitos_value <= PKT_EMPTY;
      digitos_valid <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      digitos_valid <= 1'b0;
      if (!enable) begin
        buffer  <= PKT_EMPTY;
        tmo_cnt <= '0;
      end else if (accept && key_val < 4'hA) begin
        buffer  <= {buffer[75:0], key_val};
        tmo_cnt <= '0;
      end else if (accept && key_val == KEY_HASH) begin
        digitos_value <= buffer;
        digitos_valid <= 1'b1;
        buffer        <= PKT_EMPTY;
        tmo_cnt       <= '0;
      end else if (accept && key_val == KEY_STAR) begin
        digitos_value <= PKT_EXIT;
        digitos_valid <= 1'b1;
        buffer        <= PKT_EMPTY;
        tmo_cnt       <= '0;
      end else if (buffer != PKT_EMPTY) begin
        if (tmo_cnt == TMO_LAST) begin
          digitos_value <= PKT_TMO;
          digitos_valid <= 1'b1;
          buffer        <= PKT_EMPTY;
          tmo_cnt       <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_teclado_senha.sv
// Directed bench for teclado_senha: a keypad model drives col_n from the
// scanned rows and a monitor records every digitos_valid strobe.
module tb_teclado_senha;

  localparam int TIMEOUT_CYC = 5000;
  localparam int HOLD = 50;
  localparam int GAP  = 40;

  localparam logic [79:0] ALL_F = {20{4'hF}};
  localparam logic [79:0] ALL_E = {20{4'hE}};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  col_n;
  logic [3:0]  lin_n;
  logic [79:0] digitos_value;
  logic        digitos_valid;

  logic [3:0]  pressed [4];
  int          n_strobe = 0;
  logic [79:0] last_pkt = '0;
  int          total = 0;
  int          bad = 0;

  teclado_senha dut (
    .clk(clk), .rst(rst), .enable(enable), .col_n(col_n),
    .lin_n(lin_n), .digitos_value(digitos_value), .digitos_valid(digitos_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!lin_n[r]) col_n = col_n & ~pressed[r];
  end

  always @(negedge clk) begin
    if (digitos_valid) begin
      n_strobe++;
      last_pkt = digitos_value;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key_pos(input logic [3:0] k, output int r, output int c);
    case (k)
      4'h1: begin r = 0; c = 0; end  4'h2: begin r = 0; c = 1; end
      4'h3: begin r = 0; c = 2; end  4'hA: begin r = 0; c = 3; end
      4'h4: begin r = 1; c = 0; end  4'h5: begin r = 1; c = 1; end
      4'h6: begin r = 1; c = 2; end  4'hB: begin r = 1; c = 3; end
      4'h7: begin r = 2; c = 0; end  4'h8: begin r = 2; c = 1; end
      4'h9: begin r = 2; c = 2; end  4'hC: begin r = 2; c = 3; end
      4'hE: begin r = 3; c = 0; end  4'h0: begin r = 3; c = 1; end
      4'hF: begin r = 3; c = 2; end  default: begin r = 3; c = 3; end
    endcase
  endtask

  task automatic set_key(input logic [3:0] k, input logic v);
    int r, c;
    key_pos(k, r, c);
    pressed[r][c] = v;
  endtask

  // 'hE stands for '*', 'hF for '#'
  task automatic press(input logic [3:0] k, input int hold, input int gap);
    set_key(k, 1'b1);
    wait_cyc(hold);
    set_key(k, 1'b0);
    wait_cyc(gap);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cyc(3);
    total++; if (lin_n !== 4'b1110) begin bad++; $display("FAIL reset_lin_n got=%b want=%b", lin_n, 4'b1110); end
    total++; if (digitos_value !== ALL_F) begin bad++; $display("FAIL reset_value got=%h want=%h", digitos_value, ALL_F); end
    total++; if (digitos_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", digitos_valid); end
    rst = 1'b0;
    wait_cyc(5);
  endtask

  task automatic test_confirm;
    int s0 = n_strobe;
    press(4'h1, HOLD, GAP); press(4'h2, HOLD, GAP); press(4'h3, HOLD, GAP);
    press(4'h4, HOLD, GAP); press(4'hF, HOLD, GAP);
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL confirm_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (last_pkt !== 80'hFFFFFFFFFFFFFFFF1234) begin bad++; $display("FAIL confirm_pkt got=%h want=%h", last_pkt, 80'hFFFFFFFFFFFFFFFF1234); end
  endtask

  task automatic test_bounce;
    int s0 = n_strobe;
    for (int i = 0; i < 10; i++) begin
      set_key(4'h5, 1'b1); wait_cyc(5);
      set_key(4'h5, 1'b0); wait_cyc(5);
    end
    press(4'h5, 100, GAP);
    total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL bounce_no_strobe got=%0d want=0", n_strobe - s0); end
    press(4'hF, HOLD, GAP);
    total++; if (last_pkt !== 80'hFFFFFFFFFFFFFFFFFFF5) begin bad++; $display("FAIL bounce_pkt got=%h want=%h", last_pkt, 80'hFFFFFFFFFFFFFFFFFFF5); end
  endtask

  task automatic test_timeout;
    int s0 = n_strobe;
    int k = 0;
    press(4'h7, HOLD, 0);
    while (n_strobe == s0 && k < TIMEOUT_CYC + 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    total++; if (n_strobe == s0) begin bad++; $display("FAIL timeout_wait got=no strobe want=strobe within %0d cycles", TIMEOUT_CYC + 100); end
    total++; if (last_pkt !== ALL_E) begin bad++; $display("FAIL timeout_pkt got=%h want=%h", last_pkt, ALL_E); end
    wait_cyc(TIMEOUT_CYC + 100);
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL timeout_single got=%0d want=1", n_strobe - s0); end
    press(4'hF, HOLD, GAP);
    total++; if (last_pkt !== ALL_F) begin bad++; $display("FAIL timeout_empty_buf got=%h want=%h", last_pkt, ALL_F); end
  endtask

  task automatic test_exit;
    int s0 = n_strobe;
    press(4'h9, HOLD, GAP); press(4'h8, HOLD, GAP); press(4'hE, HOLD, GAP);
    total++; if (last_pkt !== 80'hFFFFFFFFFFFFFFFFFFFB) begin bad++; $display("FAIL exit_pkt got=%h want=%h", last_pkt, 80'hFFFFFFFFFFFFFFFFFFFB); end
    press(4'hF, HOLD, GAP);
    total++; if (last_pkt !== ALL_F) begin bad++; $display("FAIL exit_then_confirm got=%h want=%h", last_pkt, ALL_F); end
    total++; if (n_strobe - s0 !== 2) begin bad++; $display("FAIL exit_strobes got=%0d want=2", n_strobe - s0); end
  endtask

  task automatic test_held_other;
    set_key(4'h2, 1'b1);
    wait_cyc(60);
    set_key(4'h6, 1'b1);
    wait_cyc(40);
    set_key(4'h2, 1'b0);
    set_key(4'h6, 1'b0);
    wait_cyc(GAP);
    press(4'hF, HOLD, GAP);
    total++; if (last_pkt !== 80'hFFFFFFFFFFFFFFFFFFF2) begin bad++; $display("FAIL held_other_pkt got=%h want=%h", last_pkt, 80'hFFFFFFFFFFFFFFFFFFF2); end
  endtask

  task automatic test_enable;
    int s0;
    press(4'h4, HOLD, GAP);
    s0 = n_strobe;
    enable = 1'b0;
    wait_cyc(10);
    total++; if (digitos_value !== 80'hFFFFFFFFFFFFFFFFFFF2) begin bad++; $display("FAIL enable_hold_value got=%h want=%h", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF2); end
    enable = 1'b1;
    wait_cyc(10);
    press(4'hF, HOLD, GAP);
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL enable_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (last_pkt !== ALL_F) begin bad++; $display("FAIL enable_flush got=%h want=%h", last_pkt, ALL_F); end
  endtask

  task automatic test_overflow;
    logic [3:0] seq [21];
    for (int i = 0; i < 20; i++) seq[i] = 4'(i % 10);
    seq[20] = 4'h3;
    for (int i = 0; i < 21; i++) press(seq[i], HOLD, GAP);
    press(4'hF, HOLD, GAP);
    total++; if (last_pkt !== 80'h12345678901234567893) begin bad++; $display("FAIL overflow_pkt got=%h want=%h", last_pkt, 80'h12345678901234567893); end
  endtask

  task automatic test_rst_mid;
    int s0 = n_strobe;
    set_key(4'h3, 1'b1);
    wait_cyc(30);
    rst = 1'b1;
    #2;
    total++; if (lin_n !== 4'b1110) begin bad++; $display("FAIL rst_mid_lin_n got=%b want=%b", lin_n, 4'b1110); end
    total++; if (digitos_value !== ALL_F) begin bad++; $display("FAIL rst_mid_value got=%h want=%h", digitos_value, ALL_F); end
    wait_cyc(3);
    set_key(4'h3, 1'b0);
    rst = 1'b0;
    wait_cyc(100);
    total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL rst_mid_no_strobe got=%0d want=0", n_strobe - s0); end
    total++; if (digitos_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", digitos_valid); end
    press(4'hF, HOLD, GAP);
    total++; if (last_pkt !== ALL_F) begin bad++; $display("FAIL rst_mid_discard got=%h want=%h", last_pkt, ALL_F); end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    rst    = 1'b1;
    enable = 1'b1;
    test_reset;
    test_confirm;
    test_bounce;
    test_timeout;
    test_exit;
    test_held_other;
    test_enable;
    test_overflow;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
